// File: rtl/debug_slave_pkg.sv
// Shared types, command-class codes and the one-hot helper for the debug-slave command queue.
package debug_slave_pkg;

  localparam int CMD_IR_WIDTH = 2;
  localparam int CMD_DR_WIDTH = 38;

  localparam logic [CMD_IR_WIDTH-1:0] MONDREG   = 2'd0;
  localparam logic [CMD_IR_WIDTH-1:0] BREAK     = 2'd1;
  localparam logic [CMD_IR_WIDTH-1:0] OCIMEM    = 2'd2;
  localparam logic [CMD_IR_WIDTH-1:0] TRACECTRL = 2'd3;

  typedef struct packed {
    logic [CMD_IR_WIDTH-1:0] ir;
    logic [CMD_DR_WIDTH-1:0] data;
  } cmd_t;

  // Wide one-hot; callers cast the result down to 2**IR_WIDTH bits.
  function automatic logic [255:0] onehot(input logic [7:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/debug_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous strobe plus a rising-edge detector.
module debug_slave_sync_edge
  import debug_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   delay;
  logic [SYNC_STAGES:0]   prime;

  // NOTE: non-blocking assignments keep every flop sampling the pre-edge value,
  // which is what makes the chain a shift register rather than a wire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync  <= '0;
      delay <= 1'b0;
      prime <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], async_in};
      delay <= sync[SYNC_STAGES-1];
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are ignored until the delay flop holds a real sample, so a strobe
  // already high at reset release does not look like a fresh rise.
  assign rise = sync[SYNC_STAGES-1] & ~delay & prime[SYNC_STAGES];

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Debug-slave command queue: synchronised vs_uir/vs_udr edges build {ir, data} commands into a FIFO
// with a valid/ready head. Optional macro DBG_CMD_PARITY_EN adds an even-parity check and error counter.
module debug_slave_cmd_queue
  import debug_slave_pkg::*;
#(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  input  logic [IR_WIDTH-1:0]       ir_in,
  input  logic [DR_WIDTH-1:0]       sr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_WIDTH-1:0]       cmd_ir,
  output logic [DR_WIDTH-1:0]       cmd_data,
  output logic [2**IR_WIDTH-1:0]    cmd_onehot,
  output logic                      cmd_action,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  input  logic                      ovf_clr
`ifdef DBG_CMD_PARITY_EN
  ,
  output logic [7:0]                parity_err_cnt
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int NCLS = 2**IR_WIDTH;

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [DR_WIDTH-1:0] data;
  } entry_t;

  logic uir_rise, udr_rise;

  debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_uir),
    .rise     (uir_rise)
  );

  debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_udr),
    .rise     (udr_rise)
  );

  logic [IR_WIDTH-1:0] ir_q;
  logic                push_vld;
  entry_t              push_cmd;
  logic                parity_ok;

`ifdef DBG_CMD_PARITY_EN
  assign parity_ok = ~^{sr[DR_WIDTH-2:0], ir_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Capture stage: a same-cycle uir rise updates ir_q only after the push has taken the old value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q     <= '0;
      push_vld <= 1'b0;
      push_cmd <= '0;
    end else begin
      if (uir_rise) ir_q <= ir_in;
      push_vld <= udr_rise & parity_ok;
      if (udr_rise) push_cmd <= '{ir: ir_q, data: sr};
    end
  end

`ifdef DBG_CMD_PARITY_EN
  logic [7:0] perr_base;
  assign perr_base = ovf_clr ? 8'd0 : parity_err_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity_err_cnt <= 8'd0;
    end else if (udr_rise && !parity_ok && perr_base != 8'd255) begin
      parity_err_cnt <= perr_base + 8'd1;
    end else begin
      parity_err_cnt <= perr_base;
    end
  end
`endif

  entry_t          mem [DEPTH];
  entry_t          head_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            pop, full, do_push, ovf_set, mem_has, head_load;

  // level counts the head register plus the entries still in storage.
  assign pop       = cmd_valid & cmd_ready;
  assign full      = (level == LW'(DEPTH));
  assign do_push   = push_vld & (~full | pop);
  assign ovf_set   = push_vld & full & ~pop;
  assign mem_has   = (level > LW'(cmd_valid));
  assign head_load = (~cmd_valid | pop) & mem_has;
  assign head_next = mem[rd_ptr];
  assign fifo_level = level;

  // NOTE: storage carries no reset; pointers and level alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_ir     <= '0;
      cmd_data   <= '0;
      cmd_onehot <= '0;
      cmd_action <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(do_push);
      rd_ptr   <= rd_ptr + PW'(head_load);
      level    <= level + LW'(do_push) - LW'(pop);
      overflow <= ovf_set | (overflow & ~ovf_clr);
      if (head_load) begin
        cmd_valid  <= 1'b1;
        cmd_ir     <= head_next.ir;
        cmd_data   <= head_next.data;
        cmd_onehot <= NCLS'(onehot(8'(head_next.ir)));
        cmd_action <= head_next.data[DR_WIDTH-1];
      end else if (pop) begin
        cmd_valid  <= 1'b0;
        cmd_ir     <= '0;
        cmd_data   <= '0;
        cmd_onehot <= '0;
        cmd_action <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Scoreboard bench for debug_slave_cmd_queue; optional DBG_CMD_PARITY_EN scenario included when defined.
module tb_debug_slave_cmd_queue;
  import debug_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vs_uir = 1'b0, vs_udr = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  cmd_onehot;
  logic        cmd_action;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        ovf_clr = 1'b0;
`ifdef DBG_CMD_PARITY_EN
  logic [7:0]  parity_err_cnt;
`endif

  int   tests = 0;
  int   fails = 0;
  cmd_t sb[$];
  logic [1:0] cur_ir = '0;

  always #5 clk = ~clk;

  debug_slave_cmd_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vs_uir     (vs_uir),
    .vs_udr     (vs_udr),
    .ir_in      (ir_in),
    .sr         (sr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_data   (cmd_data),
    .cmd_onehot (cmd_onehot),
    .cmd_action (cmd_action),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`ifdef DBG_CMD_PARITY_EN
    ,
    .parity_err_cnt (parity_err_cnt)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] make_sr(input logic [37:0] d);
    logic [37:0] r;
    r = d;
`ifdef DBG_CMD_PARITY_EN
    r[36] = ^{r[35:0], cur_ir};
`endif
    return r;
  endfunction

  task automatic send_uir(input logic [1:0] ir);
    ir_in = ir; vs_uir = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    repeat (4) tick();
    cur_ir = ir;
  endtask

  task automatic send_udr(input logic [37:0] d, input bit accepted);
    cmd_t e;
    e.ir = cur_ir; e.data = make_sr(d);
    if (accepted) sb.push_back(e);
    sr = e.data; vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_drain(input int n, input string tag);
    int   got = 0;
    int   budget = 0;
    cmd_t e;
    cmd_ready = 1'b1;
    while (got < n && budget < 40) begin
      if (cmd_valid) begin
        e = sb.pop_front();
        tests++;
        if ({cmd_ir, cmd_data, cmd_onehot, cmd_action} !==
            {e.ir, e.data, 4'(4'b0001 << e.ir), e.data[37]}) begin
          fails++;
          $display("FAIL %s pop%0d: got ir=%0d data=%h oh=%b act=%b, want ir=%0d data=%h oh=%b act=%b",
                   tag, got, cmd_ir, cmd_data, cmd_onehot, cmd_action,
                   e.ir, e.data, 4'(4'b0001 << e.ir), e.data[37]);
        end
        got++;
      end
      tick();
      budget++;
    end
    cmd_ready = 1'b0;
    if (got < n) begin
      tests++; fails++;
      $display("FAIL %s drain timeout: got %0d of %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tests++;
    if ({cmd_valid, fifo_level, overflow, cmd_ir, cmd_data, cmd_onehot, cmd_action} !== '0) begin
      fails++;
      $display("FAIL reset outputs: valid=%b lvl=%0d ovf=%b ir=%0d data=%h oh=%b act=%b, want all 0",
               cmd_valid, fifo_level, overflow, cmd_ir, cmd_data, cmd_onehot, cmd_action);
    end
    repeat (6) tick();
  endtask

  task automatic test_latency();
    cmd_t e;
    send_uir(2'd2);
    e.ir = cur_ir; e.data = make_sr(38'h20_0000_1234);
    sb.push_back(e);
    sr = e.data; vs_udr = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 3) begin
        tests++;
        if (cmd_valid !== 1'b0) begin
          fails++; $display("FAIL latency early: valid=%b after cycle 3, want 0", cmd_valid);
        end
      end
    end
    tests++;
    if (cmd_valid !== 1'b1) begin
      fails++; $display("FAIL latency: valid=%b after cycle 4, want 1", cmd_valid);
    end
    tests++;
    if ({cmd_ir, cmd_onehot, cmd_action} !== {2'd2, 4'b0100, 1'b1}) begin
      fails++;
      $display("FAIL latency head: ir=%0d oh=%b act=%b, want 2 0100 1", cmd_ir, cmd_onehot, cmd_action);
    end
    vs_udr = 1'b0;
    repeat (3) tick();
    test_drain(1, "latency");
    tests++;
    if ({cmd_valid, cmd_onehot, cmd_action} !== '0) begin
      fails++; $display("FAIL empty head: valid=%b oh=%b act=%b, want 0", cmd_valid, cmd_onehot, cmd_action);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) send_udr(38'(i), i <= 4);
    tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      fails++; $display("FAIL fill: level=%0d ovf=%b, want 4 1", fifo_level, overflow);
    end
    test_drain(4, "fill");
    tests++;
    if (overflow !== 1'b1 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL ovf sticky: ovf=%b level=%0d, want 1 0", overflow, fifo_level);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_clr: ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    cmd_t e, h;
    for (int i = 11; i <= 14; i++) send_udr(38'(i), 1'b1);
    tests++;
    if (fifo_level !== 3'd4) begin
      fails++; $display("FAIL full_pop prefill: level=%0d, want 4", fifo_level);
    end
    e.ir = cur_ir; e.data = make_sr(38'd15);
    sb.push_back(e);
    sr = e.data; vs_udr = 1'b1;
    repeat (3) tick();
    cmd_ready = 1'b1;
    h = sb.pop_front();
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== h.data) begin
      fails++; $display("FAIL full_pop head: valid=%b data=%h, want 1 %h", cmd_valid, cmd_data, h.data);
    end
    tick();
    cmd_ready = 1'b0;
    tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      fails++; $display("FAIL full_pop: level=%0d ovf=%b, want 4 0", fifo_level, overflow);
    end
    vs_udr = 1'b0;
    repeat (4) tick();
    test_drain(4, "full_pop");
  endtask

  task automatic test_same_cycle();
    cmd_t e;
    send_uir(2'd1);
    e.ir = cur_ir; e.data = make_sr(38'h77);
    sb.push_back(e);
    ir_in = 2'd3; sr = e.data;
    vs_uir = 1'b1; vs_udr = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (4) tick();
    cur_ir = 2'd3;
    send_udr(38'h88, 1'b1);
    test_drain(2, "same_cycle");
  endtask

  task automatic test_mid_reset();
    for (int i = 21; i <= 23; i++) send_udr(38'(i), 1'b0);
    tests++;
    if (fifo_level !== 3'd3) begin
      fails++; $display("FAIL mid_reset prefill: level=%0d, want 3", fifo_level);
    end
    vs_udr = 1'b1; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cur_ir = 2'd0;
    repeat (10) tick();
    tests++;
    if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL mid_reset phantom: valid=%b level=%0d, want 0 0", cmd_valid, fifo_level);
    end
    vs_udr = 1'b0;
    repeat (4) tick();
    send_udr(38'h31, 1'b1);
    tests++;
    if (fifo_level !== 3'd1) begin
      fails++; $display("FAIL mid_reset retoggle: level=%0d, want 1", fifo_level);
    end
    test_drain(1, "mid_reset");
  endtask

`ifdef DBG_CMD_PARITY_EN
  task automatic test_parity();
    logic [37:0] s;
    s = make_sr(38'h55);
    s[36] = ~s[36];
    sr = s; vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    tests++;
    if (fifo_level !== 3'd0 || parity_err_cnt !== 8'd1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL parity bad: level=%0d cnt=%0d ovf=%b, want 0 1 0", fifo_level, parity_err_cnt, overflow);
    end
    send_udr(38'h55, 1'b1);
    test_drain(1, "parity");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill_overflow();
    test_full_pop();
    test_same_cycle();
    test_mid_reset();
`ifdef DBG_CMD_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_slave_cmd_queue.md
Name: debug_slave_cmd_queue

Overview:
Parametrised successor to the debug-slave sysclk-side command logic. It samples the virtual-JTAG update strobes (vs_uir, vs_udr), which are asynchronous to clk, through a synchronizer and detects their rising edges. Each completed DR update becomes a command {ir, data}, which is queued in a DEPTH-entry FIFO. Commands are presented to the CPU debug core with a valid/ready handshake and a one-hot IR decode, replacing the single-shot take_action strobes.

Parameters:
IR_WIDTH, 2, virtual IR width; decodes to 2**IR_WIDTH command classes
DR_WIDTH, 38, shift-register (sr) and command data width
DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchronizer flops on vs_uir/vs_udr; >=2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
vs_uir  in  1  virtual update-IR level, asynchronous to clk
vs_udr  in  1  virtual update-DR level, asynchronous to clk
ir_in  in  IR_WIDTH  virtual IR value, quasi-static while vs_uir is high
sr  in  DR_WIDTH  JTAG shift register, quasi-static while vs_udr is high
cmd_valid  out  1  head command available
cmd_ready  in  1  consumer accepts head
cmd_ir  out  IR_WIDTH  head IR
cmd_data  out  DR_WIDTH  head data
cmd_onehot  out  2**IR_WIDTH  one-hot of cmd_ir; all zero when !cmd_valid
cmd_action  out  1  cmd_data[DR_WIDTH-1] when cmd_valid, else 0 (take_action vs take_no_action)
fifo_level  out  $clog2(DEPTH)+1  number of occupied entries
overflow  out  1  sticky: a command was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (reset_n low at a clk edge): sync chains 0; edge registers 0; ir_q 0; FIFO empty; cmd_valid 0; fifo_level 0; overflow 0; cmd_* outputs 0.
- Synchronizer: SYNC_STAGES-flop chain per strobe, plus one delay flop. rise = last_stage & ~delay.
- uir rise: ir_q <= ir_in, sampled on the same cycle as the rise.
- udr rise: push {ir_q, sr}. If uir rise and udr rise occur in the same cycle, the push uses the old ir_q; ir_q updates afterwards.
- Latency: when vs_udr is first sampled high on cycle 0 into an empty FIFO, cmd_valid goes high on cycle SYNC_STAGES+2.
- Pop occurs when cmd_valid & cmd_ready. The head is registered and the next entry is visible on the following cycle. There is no combinational path from cmd_ready to cmd_valid.
- Push rules:
  - Full, no pop: the push is dropped and overflow <= 1. FIFO contents are unchanged.
  - Full with a simultaneous pop: the push is accepted and the level stays DEPTH.
  - Empty with a simultaneous push and pop: the pop is ignored because cmd_valid was 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The level counter saturates at neither end; it is always kept consistent.
- ovf_clr and a new overflow event in the same cycle: set wins.
- Mid-operation reset flushes all queued commands. Any strobe already high at reset release is not seen as a rise until it drops and rises again, because the delay flop fills with 1 before an edge is detected. This is an accepted one-command loss.
- No internal FSM beyond the FIFO. States are implied by level: EMPTY (0), PARTIAL, FULL (DEPTH).

Optional Feature:
DBG_CMD_PARITY_EN
- Defined:
  - sr[DR_WIDTH-2] is an even-parity bit over sr[DR_WIDTH-3:0] plus ir_q.
  - A command with bad parity is not pushed.
  - Extra output parity_err_cnt[7:0] increments and saturates at 255. It resets to 0 and is cleared by ovf_clr.
  - Parity errors and overflow checks are independent; a parity-bad command never sets overflow.
- Undefined: no parity check, no parity_err_cnt port; all commands are pushed.

Decomposition:
- Package debug_slave_pkg holds:
  - the cmd_t struct {ir, data}, parametrised through localparams
  - localparam command-class codes: MONDREG=0, BREAK=1, OCIMEM=2, TRACECTRL=3
  - the onehot function
- One sub-module, debug_slave_sync_edge: the SYNC_STAGES synchronizer plus rise detector, instantiated twice.

Test Plan:
- Edge and latency: after reset, raise vs_uir with ir_in=2, drop it, then raise vs_udr with sr=38'h20_0000_1234 -> cmd_valid high exactly 4 cycles after vs_udr is sampled high; cmd_ir=2, cmd_onehot=4'b0100, cmd_action=1, cmd_data=38'h20_0000_1234.
- Fill and overflow: with cmd_ready=0, issue 5 udr pulses with data 1..5 -> fifo_level=4, overflow=1; drain returns 1,2,3,4 in order; ovf_clr -> overflow=0.
- Full with simultaneous pop: at level 4, hold cmd_ready=1 in the cycle the 5th push lands -> level stays 4, overflow stays 0, data 5 is delivered last.
- Same-cycle uir/udr rise: ir_q=1, then ir_in=3 with both strobes rising together -> queued cmd_ir=1; the next command gets cmd_ir=3.
- Reset mid-queue: 3 entries queued, pulse reset_n low for 1 cycle with vs_udr held high -> cmd_valid=0, level=0, no phantom push until vs_udr toggles.
- (DBG_CMD_PARITY_EN) Send sr with a flipped parity bit -> no push, parity_err_cnt=1; a following correct command is queued normally.
